frame_update_master: RTL and testbench

FRAME_UPDATE_MASTER -- requirements
Module: frame_update_master

---
 rtl/frame_update_master.sv | 183 ++++++++++++++++++
 tb/tb_frame_update_master.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_update_master.sv
// Shadow register bank that flushes dirty entries to an Avalon-MM responder on commit.
// Optional macro FRAME_SYNC_EN defers each flush until the next frame_sync pulse.
module frame_update_master #(
    parameter int NUM_REGS   = 14,
    parameter int SHIFT_ADDR = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_write,
    input  logic [3:0]  cfg_address,
    input  logic [15:0] cfg_writedata,
    input  logic        commit,
    input  logic        frame_sync,
    output logic [5:0]  avm_address,
    output logic [15:0] avm_writedata,
    output logic        avm_write,
    output logic        avm_chipselect,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done
);
    typedef enum logic [2:0] {IDLE, ARMED, ISSUE, SHIFT_CLR, FINISH} state_t;

    localparam logic [3:0] SHIFT_IDX = 4'(SHIFT_ADDR);

    state_t                state_q, state_d;
    logic [15:0]           shadow_q [NUM_REGS];
    logic [15:0]           shadow_d [NUM_REGS];
    logic [NUM_REGS-1:0]   dirty_q, dirty_d;
    logic                  pending_q, pending_d;
    logic                  wr_q, wr_d;
    logic [3:0]            addr_q, addr_d;
    logic [15:0]           data_q, data_d;
    logic                  rewr_q, rewr_d;

    logic                  cfg_hit, accept, scan_all, load;
    logic                  sel_found;
    logic [3:0]            sel_idx;
    logic [15:0]           sel_data;

`ifndef FRAME_SYNC_EN
    logic unused_frame_sync;
    assign unused_frame_sync = frame_sync;
`endif

    assign cfg_hit  = cfg_write && ({1'b0, cfg_address} < 5'(NUM_REGS));
    assign accept   = wr_q && !avm_waitrequest;
    // Mid-flush only indices above the one just written are eligible; the rest wait for the next flush.
    assign scan_all = !(state_q == ISSUE || state_q == SHIFT_CLR);

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_data  = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if ((dirty_q[i] || (cfg_hit && cfg_address == 4'(i))) &&
                (scan_all || 4'(i) > addr_q)) begin
                sel_found = 1'b1;
                sel_idx   = 4'(i);
                sel_data  = (cfg_hit && cfg_address == 4'(i)) ? cfg_writedata : shadow_q[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        dirty_d   = dirty_q;
        pending_d = pending_q | (commit && state_q != IDLE);
        wr_d      = wr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rewr_d    = rewr_q;
        load      = 1'b0;

        // A rewrite of the in-flight index while stalled must survive the eventual acceptance.
        if (state_q == ISSUE && wr_q && !accept && cfg_hit && cfg_address == addr_q)
            rewr_d = 1'b1;

        for (int i = 0; i < NUM_REGS; i++) begin
            if (state_q == ISSUE && accept && addr_q == 4'(i) && !rewr_q)
                dirty_d[i] = 1'b0;
            if (cfg_hit && cfg_address == 4'(i)) begin
                dirty_d[i]  = 1'b1;
                shadow_d[i] = cfg_writedata;
            end
        end

        case (state_q)
            IDLE: begin
                if (commit) begin
`ifdef FRAME_SYNC_EN
                    state_d = ARMED;
`else
                    state_d = ISSUE;
                    load    = 1'b1;
`endif
                end
            end
            ARMED: begin
`ifdef FRAME_SYNC_EN
                if (frame_sync) begin
                    state_d = ISSUE;
                    load    = 1'b1;
                end
`else
                state_d = IDLE;
`endif
            end
            ISSUE: begin
                if (!wr_q) begin
                    state_d = FINISH;
                end else if (accept) begin
                    if (addr_q == SHIFT_IDX) begin
                        state_d = SHIFT_CLR;
                        data_d  = '0;
                    end else begin
                        load    = 1'b1;
                        state_d = sel_found ? ISSUE : FINISH;
                    end
                end
            end
            SHIFT_CLR: begin
                if (accept) begin
                    load    = 1'b1;
                    state_d = sel_found ? ISSUE : FINISH;
                end
            end
            FINISH: begin
                if (pending_q || commit) begin
                    pending_d = 1'b0;
`ifdef FRAME_SYNC_EN
                    state_d   = ARMED;
`else
                    state_d   = ISSUE;
                    load      = 1'b1;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            wr_d   = sel_found;
            rewr_d = 1'b0;
            if (sel_found) begin
                addr_d = sel_idx;
                data_d = (sel_idx == SHIFT_IDX) ? 16'd1 : sel_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            dirty_q   <= '0;
            pending_q <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            rewr_q    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            dirty_q   <= dirty_d;
            pending_q <= pending_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rewr_q    <= rewr_d;
            shadow_q  <= shadow_d;
        end
    end

    assign avm_write      = wr_q;
    assign avm_chipselect = wr_q;
    assign avm_address    = {2'b00, addr_q};
    assign avm_writedata  = data_q;
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == FINISH);
endmodule

// File: tb/tb_frame_update_master.sv
// Randomized and directed bench for frame_update_master against a flush-list reference model.
module tb_frame_update_master;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_write = 1'b0;
    logic [3:0]  cfg_address = '0;
    logic [15:0] cfg_writedata = '0;
    logic        commit = 1'b0;
    logic        frame_sync = 1'b0;
    logic [5:0]  avm_address;
    logic [15:0] avm_writedata;
    logic        avm_write;
    logic        avm_chipselect;
    logic        avm_waitrequest = 1'b0;
    logic        busy;
    logic        done;

    int n_chk = 0;
    int n_err = 0;
    int done_cnt = 0;
    int done_base = 0;
    int wait_mode = 0;

    logic [21:0] got_q[$];
    logic [21:0] exp_q[$];
    logic [15:0] m_data [14];
    bit          m_dirty [14];

    frame_update_master dut (
        .clk(clk), .reset(reset), .cfg_write(cfg_write), .cfg_address(cfg_address),
        .cfg_writedata(cfg_writedata), .commit(commit), .frame_sync(frame_sync),
        .avm_address(avm_address), .avm_writedata(avm_writedata), .avm_write(avm_write),
        .avm_chipselect(avm_chipselect), .avm_waitrequest(avm_waitrequest),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (avm_write && !avm_waitrequest) got_q.push_back({avm_address, avm_writedata});
            if (avm_write || avm_chipselect) check("chipselect", avm_chipselect, avm_write);
            if (done) done_cnt++;
        end
    end

    // 0: responder always ready, 1: random stalls, 2: stalled
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (wait_mode)
                1:       avm_waitrequest = ($urandom_range(0, 2) == 0);
                2:       avm_waitrequest = 1'b1;
                default: avm_waitrequest = 1'b0;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        for (int i = 0; i < 14; i++) begin
            m_data[i]  = '0;
            m_dirty[i] = 1'b0;
        end
    endtask

    task automatic m_flush();
        for (int i = 0; i < 14; i++) begin
            if (m_dirty[i]) begin
                if (i == 4) begin
                    exp_q.push_back({6'd4, 16'd1});
                    exp_q.push_back({6'd4, 16'd0});
                end else begin
                    exp_q.push_back({6'(i), m_data[i]});
                end
                m_dirty[i] = 1'b0;
            end
        end
    endtask

    task automatic cfg(input logic [3:0] a, input logic [15:0] d);
        cfg_write = 1'b1;
        cfg_address = a;
        cfg_writedata = d;
        step();
        cfg_write = 1'b0;
        if (a < 14) begin
            m_data[a]  = d;
            m_dirty[a] = 1'b1;
        end
    endtask

    task automatic do_commit();
        done_base = done_cnt;
        m_flush();
        commit = 1'b1;
        step();
        commit = 1'b0;
`ifdef FRAME_SYNC_EN
        repeat ($urandom_range(1, 4)) step();
        frame_sync = 1'b1;
        step();
        frame_sync = 1'b0;
`endif
    endtask

    task automatic wait_done(input int n, input string tag);
        int cyc = 0;
        while (done_cnt < done_base + n && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 1000) check({tag, "_timeout"}, done_cnt - done_base, n);
        repeat (4) @(negedge clk);
        check({tag, "_done"}, done_cnt - done_base, n);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check({tag, "_xfer"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
        step();
    endtask

    initial begin
        m_reset();
        repeat (3) step();
        @(negedge clk);
        check("rst_write", avm_write, 0);
        check("rst_cs", avm_chipselect, 0);
        check("rst_addr", avm_address, 0);
        check("rst_data", avm_writedata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        step();
        reset = 1'b0;
        step();

`ifndef FRAME_SYNC_EN
        // Two-register flush with exact cycle positions
        cfg(4'd5, 16'h0120);
        cfg(4'd6, 16'h00F1);
        done_base = done_cnt;
        m_flush();
        commit = 1'b1;
        step();
        commit = 1'b0;
        @(negedge clk);
        check("lat_w1", {avm_write, avm_address, avm_writedata}, {1'b1, 6'd5, 16'h0120});
        check("lat_busy", busy, 1);
        @(negedge clk);
        check("lat_w2", {avm_write, avm_address, avm_writedata}, {1'b1, 6'd6, 16'h00F1});
        @(negedge clk);
        check("lat_done", {avm_write, done}, 2'b01);
        @(negedge clk);
        check("lat_idle", {busy, done}, 2'b00);
        wait_done(1, "pair");

        // Shift register pulse
        cfg(4'd4, 16'h0001);
        done_base = done_cnt;
        m_flush();
        commit = 1'b1;
        step();
        commit = 1'b0;
        @(negedge clk);
        check("shift_set", {avm_write, avm_address, avm_writedata}, {1'b1, 6'd4, 16'h0001});
        @(negedge clk);
        check("shift_clr", {avm_write, avm_address, avm_writedata}, {1'b1, 6'd4, 16'h0000});
        @(negedge clk);
        check("shift_done", done, 1);
        wait_done(1, "shift");

        // Stall on first write holds address and data for four cycles
        cfg(4'd9, 16'hABCD);
        cfg(4'd11, 16'h1111);
        done_base = done_cnt;
        m_flush();
        wait_mode = 2;
        commit = 1'b1;
        step();
        commit = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_hold", {avm_write, avm_address, avm_writedata}, {1'b1, 6'd9, 16'hABCD});
            step();
        end
        wait_mode = 0;
        @(negedge clk);
        check("stall_last", {avm_write, avm_address, avm_writedata, avm_waitrequest},
              {1'b1, 6'd9, 16'hABCD, 1'b0});
        wait_done(1, "stall");

        // Commit while busy queues exactly one extra flush
        cfg(4'd3, 16'h0303);
        done_base = done_cnt;
        m_flush();
        wait_mode = 2;
        commit = 1'b1;
        step();
        commit = 1'b0;
        step();
        commit = 1'b1;
        m_flush();
        step();
        commit = 1'b0;
        wait_mode = 0;
        wait_done(2, "pending");
`else
        // Flush waits for frame_sync; coincident frame_sync in IDLE is ignored
        begin
            int wr_seen = 0;
            cfg(4'd1, 16'h0011);
            done_base = done_cnt;
            m_flush();
            commit = 1'b1;
            frame_sync = 1'b1;
            step();
            commit = 1'b0;
            frame_sync = 1'b0;
            repeat (100) begin
                @(negedge clk);
                if (avm_write) wr_seen++;
            end
            check("armed_no_write", wr_seen, 0);
            check("armed_busy", busy, 1);
            @(posedge clk);
            #1 frame_sync = 1'b1;
            @(posedge clk);
            #1 frame_sync = 1'b0;
            @(negedge clk);
            check("fs_first", {avm_write, avm_address, avm_writedata}, {1'b1, 6'd1, 16'h0011});
            wait_done(1, "fsync");
        end
`endif

        // Lower-index write during a stalled flush is deferred to the next flush
        cfg(4'd7, 16'h0777);
        wait_mode = 2;
        do_commit();
        step();
        cfg(4'd2, 16'h0050);
        step();
        wait_mode = 0;
        wait_done(1, "defer1");
        do_commit();
        wait_done(1, "defer2");

        // Reset during a stall drops the write and discards dirty state
        cfg(4'd8, 16'h0808);
        wait_mode = 2;
        do_commit();
        step();
        reset = 1'b1;
        step();
        @(negedge clk);
        check("mid_rst_write", {avm_write, avm_chipselect}, 2'b00);
        check("mid_rst_outs", {avm_address, avm_writedata, busy, done}, '0);
        m_reset();
        got_q.delete();
        exp_q.delete();
        step();
        reset = 1'b0;
        wait_mode = 0;
        step();
        do_commit();
        wait_done(1, "post_rst");

        // Random configuration bursts with random responder stalls
        wait_mode = 1;
        for (int it = 0; it < 25; it++) begin
            int nw;
            nw = $urandom_range(0, 5);
            for (int w = 0; w < nw; w++)
                cfg(4'($urandom_range(0, 15)), 16'($urandom));
            do_commit();
            wait_done(1, "rand");
        end
        wait_mode = 0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
